// File: rtl/intr_ctrl_if.sv
// Interrupt controller bus: CPU-side requests/boundaries in,
// stack and PC strobes out.
interface intr_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 10
);
  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_in;
  logic             instr_end;
  logic             reti;
  logic             push;
  logic             pop;
  logic             s_intr;
  logic             pc_load;
  logic [PC_W-1:0]  pc_vec;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] in_service;
  logic             busy;

  modport master (
    output irq, mask_we, mask_in,
    output instr_end, reti,
    input  push, pop, s_intr, pc_load,
    input  pc_vec, pending, in_service, busy
  );

  modport slave (
    input  irq, mask_we, mask_in,
    input  instr_end, reti,
    output push, pop, s_intr, pc_load,
    output pc_vec, pending, in_service, busy
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: sync/edge-detect, pending+mask, entry/exit FSM.
// Define NESTED_INTR_EN to allow preemption by higher-priority lines.
module intr_ctrl #(
  parameter int              N_IRQ    = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = PC_W'(10'h3F0)
) (
  input logic       clk,
  input logic       reset,
  intr_ctrl_if.slave bus
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    SERVICE,
    EXIT
  } state_e;

  state_e state_q, state_d;

  logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q, edge_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] in_svc_q, in_svc_d;
  logic [PC_W-1:0]  vec_q, vec_d;

  logic [N_IRQ-1:0] req, sel_oh;
  logic [IW-1:0]    sel_idx;
  logic             take;

`ifdef NESTED_INTR_EN
  logic [N_IRQ-1:0] svc_top, below;

  // Only lines strictly above the current top priority may preempt;
  // with nothing in service every line qualifies.
  assign svc_top = in_svc_q & (~in_svc_q + ONE);
  assign below   = svc_top - ONE;
  assign req     = pending_q & mask_q & below;
`else
  assign req     = pending_q & mask_q;
`endif

  assign sel_oh = req & (~req + ONE);

  always_comb begin
    sel_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    in_svc_d  = in_svc_q;
    vec_d     = vec_q;
    take      = 1'b0;
    unique case (state_q)
      IDLE: take = bus.instr_end & (|req);
      ENTER: state_d = SERVICE;
      SERVICE: begin
        if (bus.reti) begin
          state_d = EXIT;
`ifdef NESTED_INTR_EN
        end else if (bus.instr_end && (|req)) begin
          take = 1'b1;
`endif
        end
      end
      EXIT: begin
`ifdef NESTED_INTR_EN
        in_svc_d = in_svc_q & ~svc_top;
        state_d  = (|in_svc_d) ? SERVICE : IDLE;
`else
        in_svc_d = '0;
        state_d  = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d   = ENTER;
      vec_d     = VEC_BASE + PC_W'(sel_idx);
      pending_d = pending_q & ~sel_oh;
      in_svc_d  = in_svc_q | sel_oh;
    end
    // A fresh edge wins over the entry clear.
    pending_d = pending_d | edge_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      in_svc_q  <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= bus.irq;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      edge_q    <= sync2_q & ~prev_q;
      pending_q <= pending_d;
      if (bus.mask_we) mask_q <= bus.mask_in;
      in_svc_q  <= in_svc_d;
      vec_q     <= vec_d;
    end
  end

  assign bus.push       = (state_q == ENTER);
  assign bus.pc_load    = (state_q == ENTER);
  assign bus.pop        = (state_q == EXIT);
  assign bus.s_intr     = (state_q == EXIT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.pc_vec     = vec_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_svc_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: per-cycle reference model plus directed
// scenarios with literal expectations.
module tb_intr_ctrl;

  localparam int N = 4;
  localparam int W = 10;
`ifdef NESTED_INTR_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  intr_ctrl_if #(.N_IRQ(N), .PC_W(W)) bif ();

  intr_ctrl #(
    .N_IRQ(N),
    .PC_W(W),
    .VEC_BASE(10'h3F0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference model: interrupt lines as a history of raw samples,
  // service as a stack of line numbers (front = most recent entry).
  logic [N-1:0] hist[5];
  logic [N-1:0] m_pend, m_mask;
  logic [W-1:0] m_vec;
  int           m_mode;  // 0 idle, 1 enter, 2 service, 3 exit
  int           svc[$];

  logic [N-1:0] s_irq, s_min;
  logic         s_we, s_ie, s_reti;

  function automatic int lowest(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction

  function automatic logic [N-1:0] svc_bits();
    logic [N-1:0] b;
    b = '0;
    foreach (svc[j]) b[svc[j]] = 1'b1;
    return b;
  endfunction

  task automatic m_reset();
    for (int j = 0; j < 5; j++) hist[j] = '0;
    m_pend = '0;
    m_mask = '0;
    m_vec  = '0;
    m_mode = 0;
    svc.delete();
  endtask

  task automatic m_step();
    logic [N-1:0] newe;
    int tk, c;
    for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = s_irq;
    newe = hist[3] & ~hist[4];
    tk = -1;
    case (m_mode)
      0: if (s_ie) tk = lowest(m_pend & m_mask);
      1: m_mode = 2;
      2: begin
        if (s_reti) m_mode = 3;
        else if (NEST && s_ie && svc.size() > 0) begin
          c = lowest(m_pend & m_mask);
          if (c >= 0 && c < svc[0]) tk = c;
        end
      end
      default: begin
        void'(svc.pop_front());
        m_mode = (NEST && svc.size() > 0) ? 2 : 0;
        if (!NEST) svc.delete();
      end
    endcase
    if (tk >= 0) begin
      m_vec = W'(32'h3F0 + tk);
      m_pend[tk] = 1'b0;
      svc.push_front(tk);
      m_mode = 1;
    end
    m_pend = m_pend | newe;
    if (s_we) m_mask = s_min;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      s_irq  = bif.irq;
      s_we   = bif.mask_we;
      s_min  = bif.mask_in;
      s_ie   = bif.instr_end;
      s_reti = bif.reti;
      #1;
      if (!reset) m_reset();
      else m_step();
      chk("m_push", 32'(bif.push), 32'(m_mode == 1));
      chk("m_pc_load", 32'(bif.pc_load), 32'(m_mode == 1));
      chk("m_pop", 32'(bif.pop), 32'(m_mode == 3));
      chk("m_s_intr", 32'(bif.s_intr), 32'(m_mode == 3));
      chk("m_busy", 32'(bif.busy), 32'(m_mode != 0));
      chk("m_pc_vec", 32'(bif.pc_vec), 32'(m_vec));
      chk("m_pending", 32'(bif.pending), 32'(m_pend));
      chk("m_in_service", 32'(bif.in_service), 32'(svc_bits()));
    end
  end

  task automatic wait_push(input string nm);
    int k;
    k = 0;
    while (bif.push !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_enter"}, 32'(bif.push), 32'd1);
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    bif.mask_we = 1'b1;
    bif.mask_in = m;
    @(negedge clk);
    bif.mask_we = 1'b0;
  endtask

  task automatic do_reti(input string nm);
    bif.reti = 1'b1;
    @(negedge clk);
    bif.reti = 1'b0;
    chk({nm, "_pop"}, 32'(bif.pop), 32'd1);
    chk({nm, "_s_intr"}, 32'(bif.s_intr), 32'd1);
    @(negedge clk);
  endtask

  int np;

  initial begin
    bif.irq       = '0;
    bif.mask_we   = 1'b0;
    bif.mask_in   = '0;
    bif.instr_end = 1'b0;
    bif.reti      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_pc_vec", 32'(bif.pc_vec), 32'd0);
    chk("rst_pending", 32'(bif.pending), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    set_mask(4'hF);
    bif.instr_end = 1'b1;

    // basic entry / exit
    bif.irq = 4'b0100;
    @(negedge clk);
    wait_push("basic");
    chk("basic_vec", 32'(bif.pc_vec), 32'h3F2);
    chk("basic_pc_load", 32'(bif.pc_load), 32'd1);
    chk("basic_insvc", 32'(bif.in_service), 32'h4);
    chk("basic_pend", 32'(bif.pending), 32'h0);
    repeat (2) @(negedge clk);
    chk("basic_service_busy", 32'(bif.busy), 32'd1);
    chk("basic_service_push", 32'(bif.push), 32'd0);
    do_reti("basic");
    chk("basic_idle", 32'(bif.busy), 32'd0);
    chk("basic_insvc_clr", 32'(bif.in_service), 32'h0);
    repeat (6) @(negedge clk);
    chk("level_noretrig", 32'(bif.busy), 32'd0);

    // priority
    bif.irq = 4'b1010;
    @(negedge clk);
    wait_push("prio1");
    chk("prio1_vec", 32'(bif.pc_vec), 32'h3F1);
    @(negedge clk);
    chk("prio_pend3", 32'(bif.pending), 32'h8);
    bif.reti = 1'b1;
    @(negedge clk);
    bif.reti = 1'b0;
    wait_push("prio2");
    chk("prio2_vec", 32'(bif.pc_vec), 32'h3F3);
    @(negedge clk);
    do_reti("prio2");

    // masking
    bif.irq = '0;
    set_mask(4'b1110);
    repeat (2) @(negedge clk);
    bif.irq = 4'b0001;
    np = 0;
    repeat (22) begin
      @(negedge clk);
      if (bif.push) np++;
    end
    chk("mask_noentry", 32'(np), 32'd0);
    chk("mask_pend0", 32'(bif.pending), 32'h1);
    set_mask(4'hF);
    wait_push("unmask");
    chk("unmask_vec", 32'(bif.pc_vec), 32'h3F0);
    @(negedge clk);
    do_reti("unmask");

    // edge arriving in the cycle its pending bit is cleared
    bif.instr_end = 1'b0;
    bif.irq = 4'b0010;
    repeat (5) @(negedge clk);
    chk("bnd_pend1", 32'(bif.pending), 32'h2);
    bif.irq = '0;
    repeat (2) @(negedge clk);
    bif.irq = 4'b0010;
    repeat (3) @(negedge clk);
    bif.instr_end = 1'b1;
    @(negedge clk);
    chk("bnd_push", 32'(bif.push), 32'd1);
    chk("bnd_vec", 32'(bif.pc_vec), 32'h3F1);
    chk("bnd_keep", 32'(bif.pending[1]), 32'd1);
    @(negedge clk);
    bif.reti = 1'b1;
    @(negedge clk);
    bif.reti = 1'b0;
    wait_push("bnd_again");
    chk("bnd_again_vec", 32'(bif.pc_vec), 32'h3F1);
    @(negedge clk);
    do_reti("bnd_again");

    // spurious reti in IDLE
    bif.instr_end = 1'b0;
    bif.reti = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("spur_pop", 32'(bif.pop), 32'd0);
    end
    bif.reti = 1'b0;
    chk("spur_busy", 32'(bif.busy), 32'd0);

    // higher-priority request during service
    bif.irq = '0;
    bif.instr_end = 1'b1;
    repeat (2) @(negedge clk);
    bif.irq = 4'b0100;
    @(negedge clk);
    wait_push("nest_l2");
    chk("nest_l2_vec", 32'(bif.pc_vec), 32'h3F2);
    repeat (2) @(negedge clk);
    bif.irq = 4'b0101;
    @(negedge clk);
    if (NEST) begin
      wait_push("nest_l0");
      chk("nest_l0_vec", 32'(bif.pc_vec), 32'h3F0);
      @(negedge clk);
      chk("nest_insvc", 32'(bif.in_service), 32'h5);
      do_reti("nest_r1");
      chk("nest_back_busy", 32'(bif.busy), 32'd1);
      chk("nest_back_insvc", 32'(bif.in_service), 32'h4);
      @(negedge clk);
      do_reti("nest_r2");
      chk("nest_idle", 32'(bif.busy), 32'd0);
    end else begin
      np = 0;
      repeat (8) begin
        @(negedge clk);
        if (bif.push) np++;
      end
      chk("flat_no_preempt", 32'(np), 32'd0);
      chk("flat_pend0", 32'(bif.pending), 32'h1);
      chk("flat_insvc", 32'(bif.in_service), 32'h4);
      do_reti("flat_r1");
      wait_push("flat_l0");
      chk("flat_l0_vec", 32'(bif.pc_vec), 32'h3F0);
      @(negedge clk);
      do_reti("flat_r2");
    end

    // asynchronous reset mid-service
    bif.irq = '0;
    set_mask(4'b1000);
    repeat (2) @(negedge clk);
    bif.irq = 4'b1110;
    @(negedge clk);
    wait_push("rst_l3");
    chk("rst_l3_vec", 32'(bif.pc_vec), 32'h3F3);
    repeat (2) @(negedge clk);
    chk("rst_pre_pend", 32'(bif.pending), 32'h6);
    chk("rst_pre_busy", 32'(bif.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(bif.busy), 32'd0);
    chk("arst_pending", 32'(bif.pending), 32'd0);
    chk("arst_insvc", 32'(bif.in_service), 32'd0);
    chk("arst_pc_vec", 32'(bif.pc_vec), 32'd0);
    chk("arst_strobes",
        32'({bif.push, bif.pop, bif.s_intr, bif.pc_load}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_masked", 32'(bif.busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
